// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, reserved payload/address values and
// the receive-side depacketizer state encoding.
package noc_pkg;

  localparam int unsigned FLIT_W      = 36;
  localparam int unsigned ADDR_LSB    = 0;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned PAYLOAD_LSB = 4;

  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [3:0]  BCAST_ADDR = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KW,
    S_TEXT
  } rx_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: head word is valid on dout whenever empty=0.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mapper_flit_rx.sv
// Mapper-node receive interface: address-filters scheduler flits into a FIFO and
// depacketizes each job into keyword-store writes and a handshaked text stream.
module mapper_flit_rx #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          ADDR_W     = 4,
  parameter logic [ADDR_W-1:0]    NODE_ADDR  = 4'b1001,
  parameter logic [ADDR_W-1:0]    BCAST_ADDR = noc_pkg::BCAST_ADDR,
  parameter int unsigned          FIFO_DEPTH = 16,
  parameter int unsigned          MAX_KW     = 8,
  parameter logic [DATA_W-1:0]    END_WORD   = noc_pkg::END_WORD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flit_valid,
  input  logic [DATA_W+ADDR_W-1:0]    flit_in,
  output logic                        kw_we,
  output logic [$clog2(MAX_KW)-1:0]   kw_addr,
  output logic [DATA_W-1:0]           kw_data,
  output logic [$clog2(MAX_KW):0]     kw_count,
  output logic                        text_valid,
  output logic [DATA_W-1:0]           text_data,
  input  logic                        text_ready,
  output logic                        job_done,
  output logic                        busy,
  output logic                        overflow,
  output logic                        err_fmt
);

  localparam int unsigned KW_AW = $clog2(MAX_KW);
  localparam int unsigned KW_CW = KW_AW + 1;

  noc_pkg::rx_state_e state_q, state_d;

  logic [DATA_W-1:0] kw_total_q, kw_total_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [KW_CW-1:0]  kw_count_q, kw_count_d;
  logic              overflow_q, overflow_d;
  logic              err_fmt_q, err_fmt_d;

  logic [ADDR_W-1:0] flit_addr;
  logic [DATA_W-1:0] flit_payload;
  logic              push_req, fifo_push, pop;
  logic [DATA_W-1:0] head;
  logic              full, empty;

  assign flit_addr    = flit_in[noc_pkg::ADDR_LSB +: ADDR_W];
  assign flit_payload = flit_in[noc_pkg::PAYLOAD_LSB +: DATA_W];
  assign push_req     = flit_valid && (flit_addr == NODE_ADDR || flit_addr == BCAST_ADDR);
  assign fifo_push    = push_req;

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (flit_payload),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    kw_total_d = kw_total_q;
    idx_d      = idx_q;
    kw_count_d = kw_count_q;
    err_fmt_d  = err_fmt_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    kw_we      = 1'b0;
    kw_addr    = '0;
    kw_data    = '0;
    text_valid = 1'b0;
    text_data  = '0;
    job_done   = 1'b0;

    unique case (state_q)
      noc_pkg::S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // A stray end marker between jobs is silently consumed.
          if (head != END_WORD) begin
            kw_total_d = head;
            idx_d      = '0;
            kw_count_d = '0;
            if (head == '0) begin
              state_d = noc_pkg::S_TEXT;
            end else begin
              if (head > DATA_W'(MAX_KW)) err_fmt_d = 1'b1;
              state_d = noc_pkg::S_KW;
            end
          end
        end
      end
      noc_pkg::S_KW: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == END_WORD) begin
            err_fmt_d = 1'b1;
            job_done  = 1'b1;
            state_d   = noc_pkg::S_IDLE;
          end else begin
            if (idx_q < DATA_W'(MAX_KW)) begin
              kw_we   = 1'b1;
              kw_addr = idx_q[KW_AW-1:0];
              kw_data = head;
            end
            idx_d = idx_q + DATA_W'(1);
            if (idx_d == kw_total_q) begin
              kw_count_d = (kw_total_q > DATA_W'(MAX_KW)) ? KW_CW'(MAX_KW)
                                                          : kw_total_q[KW_CW-1:0];
              state_d    = noc_pkg::S_TEXT;
            end
          end
        end
      end
      noc_pkg::S_TEXT: begin
        if (!empty) begin
          if (head == END_WORD) begin
            pop      = 1'b1;
            job_done = 1'b1;
            state_d  = noc_pkg::S_IDLE;
          end else begin
            text_valid = 1'b1;
            text_data  = head;
            pop        = text_ready;
          end
        end
      end
      default: state_d = noc_pkg::S_IDLE;
    endcase

    if (push_req && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= noc_pkg::S_IDLE;
      kw_total_q <= '0;
      idx_q      <= '0;
      kw_count_q <= '0;
      overflow_q <= 1'b0;
      err_fmt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kw_total_q <= kw_total_d;
      idx_q      <= idx_d;
      kw_count_q <= kw_count_d;
      overflow_q <= overflow_d;
      err_fmt_q  <= err_fmt_d;
    end
  end

  assign kw_count = kw_count_q;
  assign busy     = (state_q != noc_pkg::S_IDLE);
  assign overflow = overflow_q;
  assign err_fmt  = err_fmt_q;

endmodule
